regfile_seq_ran: RTL and testbench

- Single-port-clock register file of 2**ADDR_WIDTH words, DATA_WIDTH bits each.
- Supports sequential (auto-incrementing pointer) writes and reads alongside random (addressed) writes and reads.
- Serves as the on-chip data buffer of the accelerator: streaming producers fill it sequentially, compute stages read and patch words at random.

---
 rtl/regfile_seq_ran.sv | 179 +++++++++++++++++
 tb/tb_regfile_seq_ran.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ran.sv
// regfile_seq_ran: 2**ADDR_WIDTH x DATA_WIDTH on-chip data buffer.
// Streaming producers fill it through an auto-incrementing write pointer.
// Compute stages read and patch words by address.
// All storage is flops with an asynchronous clear.
// Every read has one cycle of latency and returns pre-write data.
// Optional build macro: REGFILE_RD_VALID_EN adds seq_r_valid / ran_r_valid.
// Each valid is high for the cycle after its read enable was accepted.
module regfile_seq_ran #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,          // active-high async reset despite the name
  input  logic                  seq_we,
  input  logic [DATA_WIDTH-1:0] seq_w_data,
  input  logic                  ran_we,
  input  logic [ADDR_WIDTH-1:0] ran_w_addr,
  input  logic [DATA_WIDTH-1:0] ran_w_data,
  input  logic                  seq_re,
  output logic [DATA_WIDTH-1:0] seq_r_data,
  output logic [ADDR_WIDTH-1:0] out_seq_r_addr,
  input  logic                  ran_re,
  input  logic [ADDR_WIDTH-1:0] ran_r_addr,
  output logic [DATA_WIDTH-1:0] ran_r_data,
`ifdef REGFILE_RD_VALID_EN
  output logic                  seq_r_valid,
  output logic                  ran_r_valid,
`endif
  output logic [ADDR_WIDTH-1:0] out_ran_r_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Read view of every stored word (driven from the per-word registers below).
  logic [DATA_WIDTH-1:0] word_s [DEPTH];

  // Pointers and registered read results.
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] seq_r_data_q, seq_r_data_d;
  logic [ADDR_WIDTH-1:0] seq_r_addr_q, seq_r_addr_d;
  logic [DATA_WIDTH-1:0] ran_r_data_q, ran_r_data_d;
  logic [ADDR_WIDTH-1:0] ran_r_addr_q, ran_r_addr_d;

  // ---------------------------------------------------------------------------
  // Storage: one register per word.
  // The random port has priority when both writes hit the same word.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  seq_hit_s;
    logic                  ran_hit_s;

    // Select this word's next value from the two write ports.
    always_comb begin
      seq_hit_s = seq_we && (wptr_q == ADDR_WIDTH'(g));
      ran_hit_s = ran_we && (ran_w_addr == ADDR_WIDTH'(g));
      if (ran_hit_s) begin
        word_d = ran_w_data;
      end else if (seq_hit_s) begin
        word_d = seq_w_data;
      end else begin
        word_d = word_q;
      end
    end

    // Word register, cleared by reset.
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign word_s[g] = word_q;
  end

  // ---------------------------------------------------------------------------
  // Sequential write pointer: advances on every sequential write.
  // It advances even when the random port wins the same word.
  // ---------------------------------------------------------------------------

  // Next write pointer; natural binary wrap at the top of the address space.
  always_comb begin
    if (seq_we) begin
      wptr_d = wptr_q + ADDR_WIDTH'(1);
    end else begin
      wptr_d = wptr_q;
    end
  end

  // Write pointer register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports.
  // Words are sampled from the registers before this edge's writes land.
  // A same-edge read therefore returns the old data.
  // ---------------------------------------------------------------------------

  // Sequential read: capture word at rptr, report its address, bump pointer.
  always_comb begin
    rptr_d       = rptr_q;
    seq_r_data_d = seq_r_data_q;
    seq_r_addr_d = seq_r_addr_q;
    if (seq_re) begin
      seq_r_data_d = word_s[rptr_q];
      seq_r_addr_d = rptr_q;
      rptr_d       = rptr_q + ADDR_WIDTH'(1);
    end else begin
      rptr_d       = rptr_q;
      seq_r_data_d = seq_r_data_q;
      seq_r_addr_d = seq_r_addr_q;
    end
  end

  // Random read: capture addressed word and its address, otherwise hold.
  always_comb begin
    ran_r_data_d = ran_r_data_q;
    ran_r_addr_d = ran_r_addr_q;
    if (ran_re) begin
      ran_r_data_d = word_s[ran_r_addr];
      ran_r_addr_d = ran_r_addr;
    end else begin
      ran_r_data_d = ran_r_data_q;
      ran_r_addr_d = ran_r_addr_q;
    end
  end

  // Read-side state: pointer and registered outputs of both read ports.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rptr_q       <= '0;
      seq_r_data_q <= '0;
      seq_r_addr_q <= '0;
      ran_r_data_q <= '0;
      ran_r_addr_q <= '0;
    end else begin
      rptr_q       <= rptr_d;
      seq_r_data_q <= seq_r_data_d;
      seq_r_addr_q <= seq_r_addr_d;
      ran_r_data_q <= ran_r_data_d;
      ran_r_addr_q <= ran_r_addr_d;
    end
  end

  assign seq_r_data     = seq_r_data_q;
  assign out_seq_r_addr = seq_r_addr_q;
  assign ran_r_data     = ran_r_data_q;
  assign out_ran_r_addr = ran_r_addr_q;

`ifdef REGFILE_RD_VALID_EN
  logic seq_r_valid_q;
  logic ran_r_valid_q;

  // Read-valid flags: each mirrors its read enable, delayed by one edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      seq_r_valid_q <= 1'b0;
      ran_r_valid_q <= 1'b0;
    end else begin
      seq_r_valid_q <= seq_re;
      ran_r_valid_q <= ran_re;
    end
  end

  assign seq_r_valid = seq_r_valid_q;
  assign ran_r_valid = ran_r_valid_q;
`endif

endmodule

// File: tb/tb_regfile_seq_ran.sv
// Scoreboard bench for regfile_seq_ran.
// The driver pushes the hand-computed result of every read it issues.
// A monitor pops and compares one cycle after each accepted read.
module tb_regfile_seq_ran;
  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk        = 1'b1;
  logic          rst_n      = 1'b1;
  logic          seq_we     = 1'b0;
  logic [DW-1:0] seq_w_data = '0;
  logic          ran_we     = 1'b0;
  logic [AW-1:0] ran_w_addr = '0;
  logic [DW-1:0] ran_w_data = '0;
  logic          seq_re     = 1'b0;
  logic          ran_re     = 1'b0;
  logic [AW-1:0] ran_r_addr = '0;
  logic [DW-1:0] seq_r_data;
  logic [AW-1:0] out_seq_r_addr;
  logic [DW-1:0] ran_r_data;
  logic [AW-1:0] out_ran_r_addr;
`ifdef REGFILE_RD_VALID_EN
  logic          seq_r_valid;
  logic          ran_r_valid;
`endif

  regfile_seq_ran #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .seq_we         (seq_we),
    .seq_w_data     (seq_w_data),
    .ran_we         (ran_we),
    .ran_w_addr     (ran_w_addr),
    .ran_w_data     (ran_w_data),
    .seq_re         (seq_re),
    .seq_r_data     (seq_r_data),
    .out_seq_r_addr (out_seq_r_addr),
    .ran_re         (ran_re),
    .ran_r_addr     (ran_r_addr),
    .ran_r_data     (ran_r_data),
`ifdef REGFILE_RD_VALID_EN
    .seq_r_valid    (seq_r_valid),
    .ran_r_valid    (ran_r_valid),
`endif
    .out_ran_r_addr (out_ran_r_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [DW-1:0] mask;
  } exp_t;

  exp_t seq_q[$];
  exp_t ran_q[$];
  int   total  = 0;
  int   passed = 0;
  logic seq_pend;
  logic ran_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Track which reads were accepted on the last edge (reset aborts them).
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      seq_pend <= 1'b0;
      ran_pend <= 1'b0;
    end else begin
      seq_pend <= seq_re;
      ran_pend <= ran_re;
    end
  end

  // Monitor: compare read results against the scoreboard on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (seq_pend) begin
      if (seq_q.size() == 0) begin
        total++;
        $display("FAIL seq_sb: read result with no expectation queued");
      end else begin
        e = seq_q.pop_front();
        check("seq_data", 32'(seq_r_data & e.mask), 32'(e.data & e.mask));
        check("seq_addr", 32'(out_seq_r_addr), 32'(e.addr));
      end
    end
    if (ran_pend) begin
      if (ran_q.size() == 0) begin
        total++;
        $display("FAIL ran_sb: read result with no expectation queued");
      end else begin
        e = ran_q.pop_front();
        check("ran_data", 32'(ran_r_data & e.mask), 32'(e.data & e.mask));
        check("ran_addr", 32'(out_ran_r_addr), 32'(e.addr));
      end
    end
`ifdef REGFILE_RD_VALID_EN
    if (!rst_n) begin
      check("seq_valid", 32'(seq_r_valid), 32'(seq_pend));
      check("ran_valid", 32'(ran_r_valid), 32'(ran_pend));
    end
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_wr(input logic [DW-1:0] d);
    seq_we = 1'b1; seq_w_data = d;
    step();
    seq_we = 1'b0;
  endtask

  task automatic ran_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ran_we = 1'b1; ran_w_addr = a; ran_w_data = d;
    step();
    ran_we = 1'b0;
  endtask

  task automatic both_wr(input logic [DW-1:0] sd, input logic [AW-1:0] a, input logic [DW-1:0] rd);
    seq_we = 1'b1; seq_w_data = sd;
    ran_we = 1'b1; ran_w_addr = a; ran_w_data = rd;
    step();
    seq_we = 1'b0; ran_we = 1'b0;
  endtask

  task automatic seq_rd(input logic [DW-1:0] ed, input logic [AW-1:0] ea);
    seq_re = 1'b1;
    seq_q.push_back('{ed, ea, 8'hFF});
    step();
    seq_re = 1'b0;
  endtask

  task automatic ran_rd(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [DW-1:0] m);
    ran_re = 1'b1; ran_r_addr = a;
    ran_q.push_back('{ed, a, m});
    step();
    ran_re = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_seq_r_data"},     32'(seq_r_data),     32'h0);
    check({tag, "_out_seq_r_addr"}, 32'(out_seq_r_addr), 32'h0);
    check({tag, "_ran_r_data"},     32'(ran_r_data),     32'h0);
    check({tag, "_out_ran_r_addr"}, 32'(out_ran_r_addr), 32'h0);
  endtask

  // Assert reset mid-cycle, check the outputs clear at once, release a cycle later.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_outputs_zero(tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  initial begin
    // Power-on reset held 15 ns, released on a falling edge.
    #15;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("por");
    step();

    // Empty memory reads back as zero.
    seq_rd(8'h00, 12'd0);
    seq_rd(8'h00, 12'd1);
    seq_rd(8'h00, 12'd2);
    pulse_reset("rst1");
    step();

    // Sequential fill and drain.
    seq_wr(8'hF3);
    seq_wr(8'h98);
    seq_wr(8'h3F);
    seq_rd(8'hF3, 12'd0);
    seq_rd(8'h98, 12'd1);
    seq_rd(8'h3F, 12'd2);

    // Advance wptr to 7, then collide both write ports on word 7.
    seq_wr(8'h03);
    seq_wr(8'h04);
    seq_wr(8'h05);
    seq_wr(8'h06);
    both_wr(8'h11, 12'd7, 8'h22);
    seq_wr(8'h33);                      // lands at 8 only if wptr advanced
    both_wr(8'h44, 12'd10, 8'h66);      // seq -> 9, ran -> 10, both kept
    ran_rd(12'd7,  8'h22, 8'hFF);
    ran_rd(12'd8,  8'h33, 8'hFF);
    ran_rd(12'd9,  8'h44, 8'hFF);
    ran_rd(12'd10, 8'h66, 8'hFF);

    // Random writes, including a word with unknown upper bits.
    ran_wr(12'd0, 8'bxxxx_0000);
    ran_wr(12'd5, 8'hA0);
    ran_wr(12'd6, 8'hA1);
    ran_rd(12'd5, 8'hA0, 8'hFF);
    ran_rd(12'd6, 8'hA1, 8'hFF);
    ran_rd(12'd0, 8'h00, 8'h0F);
    seq_rd(8'h03, 12'd3);

    // Read-during-write on word 5 returns old data, then the new data.
    ran_re = 1'b1; ran_r_addr = 12'd5;
    ran_we = 1'b1; ran_w_addr = 12'd5; ran_w_data = 8'h55;
    ran_q.push_back('{8'hA0, 12'd5, 8'hFF});
    step();
    ran_we = 1'b0; ran_re = 1'b0;
    ran_rd(12'd5, 8'h55, 8'hFF);

    // Outputs hold while the read enables stay low.
    step();
    step();
    check("hold_ran_data", 32'(ran_r_data),     32'h55);
    check("hold_ran_addr", 32'(out_ran_r_addr), 32'd5);
    check("hold_seq_data", 32'(seq_r_data),     32'h03);
    check("hold_seq_addr", 32'(out_seq_r_addr), 32'd3);

    // Pointer wrap: full sweep plus one overwrites word 0.
    pulse_reset("rst2");
    step();
    for (int i = 0; i < DEPTH; i++) seq_wr(8'(i) ^ 8'h5A);
    seq_wr(8'hC3);
    ran_rd(12'd0,    8'hC3, 8'hFF);
    ran_rd(12'd1,    8'h5B, 8'hFF);
    ran_rd(12'd4095, 8'hA5, 8'hFF);
    for (int i = 0; i <= DEPTH; i++) begin
      seq_rd((i == 0 || i == DEPTH) ? 8'hC3 : (8'(i) ^ 8'h5A), 12'(i % DEPTH));
    end

    // Reset in the middle of a stream: the edge under reset does nothing.
    seq_we = 1'b1; seq_w_data = 8'h77; seq_re = 1'b1;
    seq_q.push_back('{8'h5B, 12'd1, 8'hFF});
    step();
    seq_w_data = 8'h88;
    pulse_reset("rst3");
    seq_we = 1'b0; seq_re = 1'b0;
    step();
    ran_rd(12'd1,    8'h00, 8'hFF);
    ran_rd(12'd4095, 8'h00, 8'hFF);
    seq_rd(8'h00, 12'd0);
    seq_wr(8'hAB);
    ran_rd(12'd0, 8'hAB, 8'hFF);

    step();
    step();
    check("seq_sb_empty", 32'(seq_q.size()), 32'd0);
    check("ran_sb_empty", 32'(ran_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
